// File: rtl/prog_ctr.sv
// prog_ctr: fetch-stage program counter sequencer.
// Selects the next instruction address each cycle (sequential, absolute
// jump or PC-relative jump) under a start/run/done control FSM, and counts
// RUN cycles with a saturating counter. All outputs are registered.
module prog_ctr #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic          Taken,
    input  logic [D-1:0]  Target,
    output logic [D-1:0]  ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [D-1:0]  r_pc;
    logic [D-1:0]  w_pc_nx;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_pc_rel;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_cnt_inc;
    logic          r_running;
    logic          r_done;

    // Address arithmetic wraps silently at 2^D; adding the raw D-bit
    // Target is the same as adding its signed value modulo 2^D.
    assign w_pc_inc  = r_pc + {{(D-1){1'b0}}, 1'b1};
    assign w_pc_rel  = r_pc + Target;

    // Run-cycle counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + {{(CW-1){1'b0}}, 1'b1});

    // Next-state, next-PC and next-count selection.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_pc_nx  = {D{1'b0}};
                w_cnt_nx = {CW{1'b0}};
                if (Start) begin
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The halting cycle still counts as a RUN cycle.
                w_cnt_nx = w_cnt_inc;
                if (Halt) begin
                    w_state_nx = ST_DONE;
                    w_pc_nx    = r_pc;
                end else if (BranchAbs && Taken) begin
                    w_pc_nx = Target;
                end else if (BranchRel && Taken) begin
                    w_pc_nx = w_pc_rel;
                end else begin
                    w_pc_nx = w_pc_inc;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    w_state_nx = ST_RUN;
                    w_pc_nx    = {D{1'b0}};
                    w_cnt_nx   = {CW{1'b0}};
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_pc_nx    = {D{1'b0}};
                w_cnt_nx   = {CW{1'b0}};
            end
        endcase
    end

    // State and output registers; active-low Reset overrides everything.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= {D{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_cnt     <= w_cnt_nx;
            r_running <= (w_state_nx == ST_RUN);
            r_done    <= (w_state_nx == ST_DONE);
        end
    end

    assign ProgCtr  = r_pc;
    assign Running  = r_running;
    assign Done     = r_done;
    assign CycleCnt = r_cnt;

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: scoreboard bench for prog_ctr. Stimulus drives inputs on the
// falling edge, advances a behavioural model and queues the expected outputs;
// a monitor pops one expectation after each rising edge and compares.
module tb_prog_ctr;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Halt;
    logic        BranchAbs;
    logic        BranchRel;
    logic        Taken;
    logic [11:0] Target;
    logic [11:0] ProgCtr;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCnt;
    logic [11:0] ProgCtr4;
    logic        Running4;
    logic        Done4;
    logic [3:0]  CycleCnt4;

    prog_ctr #(.D(12), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
        .Target(Target), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .CycleCnt(CycleCnt)
    );

    // Narrow-counter instance for saturation; shares all inputs.
    prog_ctr #(.D(12), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
        .Target(Target), .ProgCtr(ProgCtr4), .Running(Running4),
        .Done(Done4), .CycleCnt(CycleCnt4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int pc;
        int running;
        int done;
        int cnt;
        int cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: mode 0 = idle, 1 = run, 2 = done.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;
    int m_cnt4 = 0;

    task automatic model_step();
        int off;
        exp_t e;
        if (Reset == 1'b0) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (m_mode == 0) begin
            if (Start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
            end
        end else if (m_mode == 1) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            if (Halt) begin
                m_mode = 2;
            end else if (BranchAbs && Taken) begin
                m_pc = int'(Target);
            end else if (BranchRel && Taken) begin
                off  = int'(Target);
                if (off >= 2048) off = off - 4096;
                m_pc = (m_pc + off + 4096) % 4096;
            end else begin
                m_pc = (m_pc + 1) % 4096;
            end
        end else begin
            if (Start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
            end
        end
        e.pc      = m_pc;
        e.running = (m_mode == 1) ? 1 : 0;
        e.done    = (m_mode == 2) ? 1 : 0;
        e.cnt     = m_cnt;
        e.cnt4    = m_cnt4;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic st, input logic hl,
                       input logic ba, input logic br, input logic tk,
                       input logic [11:0] tg);
        @(negedge Clk);
        Reset = rst; Start = st; Halt = hl;
        BranchAbs = ba; BranchRel = br; Taken = tk; Target = tg;
        model_step();
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising edge the DUT presents a new registered result.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",       int'(ProgCtr),   e.pc);
            check("running",  int'(Running),   e.running);
            check("done",     int'(Done),      e.done);
            check("cyclecnt", int'(CycleCnt),  e.cnt);
            check("pc_cw4",   int'(ProgCtr4),  e.pc);
            check("cnt_cw4",  int'(CycleCnt4), e.cnt4);
        end
    end

    initial begin
        int wait_cnt;
        Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
        BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0; Target = 12'd0;

        // Reset and start: PC 0..5, count 5.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        // Jumps from PC=10.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd10);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd94);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFB);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd33);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd100);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'd7);

        // Wrap-around cases.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd4095);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFB);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd4090);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd20);

        // Halt beats a simultaneous branch; Done holds; Start restarts.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd7);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'd118);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd55);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        // Mid-run reset with Start also high; then idle ignores branches.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd50);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd77);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0);

        // Saturation of the 4-bit counter over 20 RUN cycles.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9)  == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                12'($urandom_range(0, 4095)));
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge Clk);
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
        BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge Clk);
            wait_cnt++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program counter sequencer for the fetch stage. It consumes the D-bit branch target produced by the branch-target lookup table and selects the next instruction address each cycle: sequential, absolute jump, or PC-relative jump. It also runs a start/run/done control FSM and a run-cycle counter used by the testbench and top level. Its ProgCtr output addresses instruction memory.

## Interface
- D, 12, PC and target width; all address arithmetic is modulo 2^D
- CW, 16, width of the run-cycle counter

- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clk
- Start  input  1  begin (or restart) program execution from address 0
- Halt  input  1  decoded halt instruction; ends the run
- BranchAbs  input  1  current instruction is an absolute jump
- BranchRel  input  1  current instruction is a PC-relative jump
- Taken  input  1  branch condition true (from ALU flags); qualifies both branch types
- Target  input  D  lookup-table output; absolute address, or two's-complement offset for relative jumps
- ProgCtr  output  D  current instruction address (registered)
- Running  output  1  high while the FSM is in RUN (registered)
- Done  output  1  high while the FSM is in DONE (registered)
- CycleCnt  output  CW  number of RUN cycles since the last Start (registered)

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset low on a rising edge puts the FSM in IDLE with ProgCtr=0, Running=0, Done=0, and CycleCnt=0. Reset overrides every other input, including in mid-run.
- IDLE: ProgCtr is held at 0. Start=1 moves the FSM to RUN with ProgCtr=0 and CycleCnt=0. All other inputs are ignored.
- RUN: next-PC priority, highest first:
  1. Halt=1 moves the FSM to DONE. ProgCtr holds, and branch inputs are ignored.
  2. BranchAbs=1 and Taken=1 sets ProgCtr=Target.
  3. BranchRel=1 and Taken=1 sets ProgCtr=(ProgCtr+Target) mod 2^D. Target is treated as signed D-bit, so 12'hFFB means -5.
  4. Otherwise ProgCtr=(ProgCtr+1) mod 2^D.
- BranchAbs and BranchRel both high with Taken=1: the absolute jump wins.
- Branch inputs with Taken=0 fall through to +1.
- Start in RUN is ignored.
- CycleCnt increments by 1 on every RUN cycle, including the cycle that sees Halt. It saturates at 2^CW-1 and does not wrap.
- DONE: ProgCtr and CycleCnt hold. Start=1 restarts: the FSM returns to RUN with ProgCtr=0 and CycleCnt=0. Other inputs are ignored.
- Wrap-around is silent:
  - 4095+1 gives 0.
  - 3+(-5) gives 4094.
  - 4090+20 gives 14.
  - No overflow flag is produced.

## Timing
- All outputs are registered. Inputs are sampled on a rising edge and the effect is visible after that edge, giving one-cycle latency.
- Halt, Branch*, Taken, and Target are combinational from the decode of the instruction at the current ProgCtr. They must be valid in the same cycle ProgCtr is presented.
- After Start is sampled in IDLE:
  - Running=1 and ProgCtr=0 on the next edge.
  - The first increment happens one edge later.
- Halt sampled in RUN gives Running=0 and Done=1 on the next edge. Done stays high until Start or Reset.
- Start must be high for at least one sampled edge. Holding it longer in RUN has no effect.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset and start: hold Reset=0 for 2 cycles, then release. Expect ProgCtr=0, Running=0, Done=0, CycleCnt=0. Pulse Start, then leave all inputs low for 5 cycles. Expect ProgCtr 0,1,2,3,4,5 and CycleCnt=5.
- Jumps from PC=10:
  - BranchAbs, Taken, Target=94 gives ProgCtr=94.
  - From 94, BranchRel, Taken, Target=12'hFFB gives 89.
  - BranchRel with Taken=0 gives 90.
  - BranchAbs and BranchRel together, Taken, Target=100 gives 100.
- Wrap-around: force PC to 4095 via BranchAbs with Target=4095, then step once and expect 0. From 3, BranchRel with Target=12'hFFB (-5) gives 4094. From 4090, BranchRel with Target=20 gives 14.
- Halt: at PC=7 assert Halt together with BranchAbs, Taken, Target=118. Expect ProgCtr to stay 7, Done=1, Running=0, and CycleCnt to freeze. Start then gives ProgCtr=0, Running=1, CycleCnt=0.
- Mid-run reset: in RUN at PC=50, drive Reset=0 for one edge. Expect ProgCtr=0, IDLE state, and CycleCnt=0. Start=1 asserted together with Reset=0 must be ignored.
- Saturation: with CW=4, run 20 cycles and expect CycleCnt to stick at 15.
